// File: rtl/booth_mult_seq_pkg.sv
// Shared ALU definitions for the sequential Booth multiplier: FSM encoding,
// Booth recoding ops and the default datapath width.
package booth_mult_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_t;

  // Radix-2 Booth recoding of the multiplier lsb and the guard bit.
  function automatic booth_op_t booth_decode(input logic lsb, input logic guard);
    case ({lsb, guard})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cla_adder_n.sv
// N-bit adder with carry-in, built from 4-bit carry-lookahead groups whose
// group generate/propagate terms are chained to form the group carries.
module cla_adder_n #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  localparam int NG = (N + 3) / 4;
  localparam int NP = NG * 4;

  logic [NP-1:0] a_ext;
  logic [NP-1:0] b_ext;
  logic [NP-1:0] p;
  logic [NP-1:0] g;
  logic [NP-1:0] c;
  logic [NP-1:0] s_ext;
  logic [NG:0]   gc;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic          unused_carry;

  // Operands are zero-padded up to a whole number of groups; pad bits are dropped.
  assign a_ext = NP'(a);
  assign b_ext = NP'(b);
  assign p     = a_ext ^ b_ext;
  assign g     = a_ext & b_ext;

  always_comb begin
    gc    = '0;
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    gc[0] = cin;
    for (int i = 0; i < NG; i++) begin
      c[4*i]     = gc[i];
      c[4*i + 1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i + 2] = g[4*i + 1] | (p[4*i + 1] & g[4*i])
                 | (p[4*i + 1] & p[4*i] & gc[i]);
      c[4*i + 3] = g[4*i + 2] | (p[4*i + 2] & g[4*i + 1])
                 | (p[4*i + 2] & p[4*i + 1] & g[4*i])
                 | (p[4*i + 2] & p[4*i + 1] & p[4*i] & gc[i]);
      grp_g[i]   = g[4*i + 3] | (p[4*i + 3] & g[4*i + 2])
                 | (p[4*i + 3] & p[4*i + 2] & g[4*i + 1])
                 | (p[4*i + 3] & p[4*i + 2] & p[4*i + 1] & g[4*i]);
      grp_p[i]   = &p[4*i +: 4];
      gc[i + 1]  = grp_g[i] | (grp_p[i] & gc[i]);
    end
  end

  assign s_ext = p ^ c;
  assign sum   = s_ext[N-1:0];

  assign unused_carry = ^{gc[NG], s_ext};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift per cycle,
// producing the low WIDTH product bits plus a signed-overflow flag.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t                  state_q, state_d;
  logic signed [WIDTH:0]   mcand_q, mcand_d;
  logic signed [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]        mplr_q, mplr_d;
  logic                    q1_q, q1_d;
  logic [CW-1:0]           count_q, count_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic                    ovf_q, ovf_d;

  booth_op_t               op;
  logic [WIDTH:0]          add_b;
  logic                    add_cin;
  logic [WIDTH:0]          add_sum;
  logic signed [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0]        mplr_sh;
  logic                    q1_sh;

  // The full product fits in WIDTH signed bits only if the upper half is a
  // pure sign extension of the low half's msb.
  function automatic logic product_overflows(input logic [WIDTH-1:0] hi,
                                             input logic             sign);
    return hi != {WIDTH{sign}};
  endfunction

  always_comb begin
    op      = booth_decode(mplr_q[0], q1_q);
    add_b   = '0;
    add_cin = 1'b0;
    unique case (op)
      OP_ADD: add_b = $unsigned(mcand_q);
      OP_SUB: begin
        add_b   = ~$unsigned(mcand_q);
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  cla_adder_n #(
    .N (WIDTH + 1)
  ) u_cla (
    .a   ($unsigned(acc_q)),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  // Arithmetic right shift of {sum, mplr, q_1}, replicating the sum's msb.
  always_comb begin
    {acc_sh, mplr_sh, q1_sh} = {add_sum[WIDTH], add_sum, mplr_q};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    q1_d     = q1_q;
    count_d  = count_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mcand_d = {operand_a[WIDTH-1], operand_a};
          acc_d   = '0;
          mplr_d  = operand_b;
          q1_d    = 1'b0;
          count_d = '0;
        end
      end
      ST_RUN: begin
        acc_d   = acc_sh;
        mplr_d  = mplr_sh;
        q1_d    = q1_sh;
        count_d = count_q + CW'(1);
        // Result and flag are captured on the edge that enters DONE.
        if (count_q == LAST_COUNT) begin
          state_d  = ST_DONE;
          result_d = mplr_sh;
          ovf_d    = product_overflows(acc_sh[WIDTH-1:0], mplr_sh[WIDTH-1]);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      q1_q     <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      q1_q     <= q1_d;
      count_q  <= count_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_ready = (state_q == ST_DONE);
  assign result       = result_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: stimulus pushes hand-computed products,
// a negedge monitor pops and checks them whenever result_ready pulses.
module tb_booth_mult_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy;
  logic         result_ready;
  logic [W-1:0] result;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           at;
  } exp_t;

  exp_t sb[$];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .result_ready (result_ready),
    .result       (result),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (result_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready actual=pulse result=%0h expected=none (cycle %0d)",
                 result, cyc);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("ready_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic eo, output int c0);
    exp_t e;
    @(posedge clock);
    #1;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    c0        = cyc;
    e.res     = er;
    e.ovf     = eo;
    e.at      = cyc + W + 1;
    sb.push_back(e);
    @(posedge clock);
    #1;
    start     = 1'b0;
    operand_a = ~a;
    operand_b = b + 1;
  endtask

  task automatic drain();
    for (int i = 0; i < W + 10 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         o;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int c0;

    vecs[0] = '{32'd3,        32'd5,        32'd15,       1'b0};
    vecs[1] = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0};
    vecs[2] = '{32'd6,        32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[5] = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[6] = '{32'd0,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[7] = '{32'hFFFFFFFD, 32'hFFFFFFFC, 32'd12,       1'b0};
    vecs[8] = '{32'h00010000, 32'h00010000, 32'd0,        1'b1};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(result_ready), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].o, c0);
      drain();
    end

    // Result must hold through idle cycles.
    issue(32'd3, 32'd5, 32'd15, 1'b0, c0);
    drain();
    repeat (3) @(posedge clock);
    #1;
    chk("result_held", 64'(result), 64'd15);
    chk("idle_busy", 64'(busy), 64'd0);

    // Starts during RUN and DONE are ignored; the next IDLE cycle accepts.
    issue(32'd3, 32'd5, 32'd15, 1'b0, c0);
    goto(c0 + 5);
    operand_a = 32'd9;
    operand_b = 32'd9;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    goto(c0 + W + 1);
    chk("done_ready", 64'(result_ready), 64'd1);
    operand_a = 32'd9;
    operand_b = 32'd9;
    start     = 1'b1;
    issue(32'd9, 32'd9, 32'd81, 1'b0, c0);
    drain();

    // Asynchronous reset mid-RUN aborts the operation and clears outputs.
    issue(32'h00001234, 32'h00000010, 32'h00012340, 1'b0, c0);
    goto(c0 + 10);
    chk("run_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(result_ready), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_overflow", 64'(overflow), 64'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (W + 5) @(posedge clock);
    #1;
    chk("post_abort_busy", 64'(busy), 64'd0);
    chk("post_abort_result", 64'(result), 64'd0);

    issue(32'd9, 32'd9, 32'd81, 1'b0, c0);
    drain();
    issue(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0, c0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
